// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enabled horizontal/vertical counters with per-axis
// phase FSMs; sync, video_on and coordinates are registered and valid together.
module vga_sync_gen #(
    parameter int CW        = 10,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_end,
    output logic          frame_end
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_FRONT_AT = CW'(H_DISPLAY);
    localparam logic [CW-1:0] H_SYNC_AT  = CW'(H_DISPLAY + H_FP);
    localparam logic [CW-1:0] H_BACK_AT  = CW'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_FRONT_AT = CW'(V_DISPLAY);
    localparam logic [CW-1:0] V_SYNC_AT  = CW'(V_DISPLAY + V_FP);
    localparam logic [CW-1:0] V_BACK_AT  = CW'(V_DISPLAY + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    phase_t          r_h_phase;
    phase_t          r_v_phase;
    phase_t          w_h_phase_nxt;
    phase_t          w_v_phase_nxt;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic [CW-1:0]   w_x_nxt;
    logic [CW-1:0]   w_y_nxt;
    logic            w_x_wrap;
    logic            w_y_wrap;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_video_on;

    // Advance the phase when the upcoming count lands on the next boundary.
    function automatic phase_t step_phase(
        input phase_t        cur,
        input logic [CW-1:0] cnt,
        input logic [CW-1:0] front_at,
        input logic [CW-1:0] sync_at,
        input logic [CW-1:0] back_at
    );
        phase_t nxt;
        nxt = cur;
        case (cur)
            PH_ACTIVE: if (cnt == front_at) nxt = PH_FRONT;
            PH_FRONT:  if (cnt == sync_at)  nxt = PH_SYNC;
            PH_SYNC:   if (cnt == back_at)  nxt = PH_BACK;
            PH_BACK:   if (cnt == '0)       nxt = PH_ACTIVE;
            default:   nxt = PH_ACTIVE;
        endcase
        return nxt;
    endfunction

    always_comb begin
        w_x_wrap = (r_x == H_LAST);
        w_y_wrap = (r_y == V_LAST);
        w_x_nxt  = w_x_wrap ? '0 : r_x + 1'b1;
        w_y_nxt  = r_y;
        if (w_x_wrap) begin
            w_y_nxt = w_y_wrap ? '0 : r_y + 1'b1;
        end
        w_h_phase_nxt = step_phase(r_h_phase, w_x_nxt, H_FRONT_AT, H_SYNC_AT, H_BACK_AT);
        w_v_phase_nxt = r_v_phase;
        if (w_x_wrap) begin
            w_v_phase_nxt = step_phase(r_v_phase, w_y_nxt, V_FRONT_AT, V_SYNC_AT, V_BACK_AT);
        end
    end

    // Flags decode the next phase so they line up with the new x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_h_phase  <= PH_ACTIVE;
            r_v_phase  <= PH_ACTIVE;
            r_hsync    <= SYNC_OFF;
            r_vsync    <= SYNC_OFF;
            r_video_on <= 1'b1;
        end else if (pix_en) begin
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_h_phase  <= w_h_phase_nxt;
            r_v_phase  <= w_v_phase_nxt;
            r_hsync    <= (w_h_phase_nxt == PH_SYNC) ? SYNC_ON : SYNC_OFF;
            r_vsync    <= (w_v_phase_nxt == PH_SYNC) ? SYNC_ON : SYNC_OFF;
            r_video_on <= (w_h_phase_nxt == PH_ACTIVE) && (w_v_phase_nxt == PH_ACTIVE);
        end
    end

    assign x         = r_x;
    assign y         = r_y;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign video_on  = r_video_on;
    assign line_end  = pix_en & w_x_wrap & ~reset;
    assign frame_end = line_end & w_y_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing plus a tiny
// positive-polarity instance small enough to sweep a whole frame.
module tb_vga_sync_gen;

    logic       clk;
    logic       d_reset, d_pix_en;
    logic [9:0] d_x, d_y;
    logic       d_hsync, d_vsync, d_video_on, d_line_end, d_frame_end;
    logic       s_reset, s_pix_en;
    logic [3:0] s_x, s_y;
    logic       s_hsync, s_vsync, s_video_on, s_line_end, s_frame_end;

    int n_checks = 0;
    int n_errors = 0;

    vga_sync_gen u_dut (
        .clk(clk), .reset(d_reset), .pix_en(d_pix_en),
        .x(d_x), .y(d_y), .hsync(d_hsync), .vsync(d_vsync),
        .video_on(d_video_on), .line_end(d_line_end), .frame_end(d_frame_end)
    );

    vga_sync_gen #(
        .CW(4), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .reset(s_reset), .pix_en(s_pix_en),
        .x(s_x), .y(s_y), .hsync(s_hsync), .vsync(s_vsync),
        .video_on(s_video_on), .line_end(s_line_end), .frame_end(s_frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_off, hs_cnt, hs_min, hs_max, le_cnt, fe_cnt, bad, wide;
        int x_at4, x_at8, vs_cnt;
        bit prev_le;
        int ex, ey;

        d_reset = 1'b1; d_pix_en = 1'b1;
        s_reset = 1'b1; s_pix_en = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_x", d_x, 0);
        check("rst_y", d_y, 0);
        check("rst_video_on", d_video_on, 1);
        check("rst_hsync", d_hsync, 1);
        check("rst_vsync", d_vsync, 1);
        check("rst_line_end", d_line_end, 0);
        check("rst_frame_end", d_frame_end, 0);
        tick();
        d_reset = 1'b0;

        // one full line at pix_en=1
        first_off = -1; hs_cnt = 0; hs_min = 9999; hs_max = -1; le_cnt = 0; fe_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (!d_video_on && first_off < 0) first_off = int'(d_x);
            if (!d_hsync) begin
                hs_cnt++;
                if (int'(d_x) < hs_min) hs_min = int'(d_x);
                if (int'(d_x) > hs_max) hs_max = int'(d_x);
            end
            if (d_line_end) le_cnt++;
            if (d_frame_end) fe_cnt++;
            tick();
        end
        check("video_off_x", first_off, 640);
        check("hsync_low_clks", hs_cnt, 96);
        check("hsync_first_x", hs_min, 656);
        check("hsync_last_x", hs_max, 751);
        check("line_end_count", le_cnt, 1);
        check("frame_end_count", fe_cnt, 0);
        @(negedge clk);
        check("line1_x", d_x, 0);
        check("line1_y", d_y, 1);
        check("line1_video_on", d_video_on, 1);
        check("line1_hsync", d_hsync, 1);
        tick();

        // reset mid-line
        repeat (299) tick();
        @(negedge clk);
        check("pre_rst_x", d_x, 300);
        check("pre_rst_y", d_y, 1);
        d_reset = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_x", d_x, 0);
        check("mid_rst_y", d_y, 0);
        check("mid_rst_hsync", d_hsync, 1);
        check("mid_rst_vsync", d_vsync, 1);
        check("mid_rst_video_on", d_video_on, 1);
        d_reset = 1'b0;

        // freeze inside hsync
        repeat (660) tick();
        @(negedge clk);
        check("hs_x660", d_x, 660);
        check("hs_hsync660", d_hsync, 0);
        check("hs_video660", d_video_on, 0);
        d_pix_en = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            if (d_x != 10'd660 || d_y != 10'd0 || d_hsync != 1'b0 || d_vsync != 1'b1 ||
                d_video_on != 1'b0 || d_line_end != 1'b0) bad++;
        end
        check("freeze_bad_cycles", bad, 0);
        d_pix_en = 1'b1;
        repeat (139) tick();
        @(negedge clk);
        check("eol_x", d_x, 799);
        d_pix_en = 1'b0;
        #1 check("le_no_en", d_line_end, 0);
        d_pix_en = 1'b1;
        #1 check("le_en", d_line_end, 1);
        check("fe_not_last_line", d_frame_end, 0);
        d_reset = 1'b1;
        #1 check("le_in_reset", d_line_end, 0);
        d_reset = 1'b0;
        tick();

        // pix_en one clock in four
        hs_cnt = 0; le_cnt = 0; wide = 0; prev_le = 1'b0; x_at4 = -1; x_at8 = -1;
        for (int i = 0; i < 3200; i++) begin
            d_pix_en = (i % 4 == 0);
            @(negedge clk);
            if (i == 4) x_at4 = int'(d_x);
            if (i == 8) x_at8 = int'(d_x);
            if (!d_hsync) hs_cnt++;
            if (d_line_end) le_cnt++;
            if (d_line_end && prev_le) wide++;
            prev_le = d_line_end;
            tick();
        end
        check("div4_x_at4", x_at4, 1);
        check("div4_x_at8", x_at8, 2);
        check("div4_hsync_low_clks", hs_cnt, 384);
        check("div4_line_end_count", le_cnt, 1);
        check("div4_line_end_wide", wide, 0);
        d_pix_en = 1'b1;
        @(negedge clk);
        check("div4_end_x", d_x, 0);
        check("div4_end_y", d_y, 2);

        // small positive-polarity instance: full frame sweep
        check("s_rst_hsync", s_hsync, 0);
        check("s_rst_vsync", s_vsync, 0);
        check("s_rst_video_on", s_video_on, 1);
        s_reset = 1'b0;
        hs_cnt = 0; vs_cnt = 0; fe_cnt = 0;
        for (int k = 0; k < 128; k++) begin
            ex = k % 16;
            ey = (k / 16) % 8;
            check("s_x", s_x, ex);
            check("s_y", s_y, ey);
            check("s_hsync", s_hsync, (ex >= 10 && ex <= 12) ? 1 : 0);
            check("s_vsync", s_vsync, (ey >= 5 && ey <= 6) ? 1 : 0);
            check("s_video_on", s_video_on, (ex < 8 && ey < 4) ? 1 : 0);
            check("s_line_end", s_line_end, (ex == 15) ? 1 : 0);
            check("s_frame_end", s_frame_end, (ex == 15 && ey == 7) ? 1 : 0);
            if (s_hsync) hs_cnt++;
            if (s_vsync) vs_cnt++;
            if (s_frame_end) fe_cnt++;
            tick();
            @(negedge clk);
        end
        check("s_hsync_high_clks", hs_cnt, 24);
        check("s_vsync_high_clks", vs_cnt, 32);
        check("s_frame_end_count", fe_cnt, 1);
        check("s_wrap_x", s_x, 0);
        check("s_wrap_y", s_y, 0);
        check("s_wrap_video_on", s_video_on, 1);

        // reset while inside vsync
        repeat (80) tick();
        @(negedge clk);
        check("s_vs_y", s_y, 5);
        check("s_vs_vsync", s_vsync, 1);
        s_reset = 1'b1;
        tick();
        @(negedge clk);
        check("s_vs_rst_x", s_x, 0);
        check("s_vs_rst_y", s_y, 0);
        check("s_vs_rst_vsync", s_vsync, 0);
        check("s_vs_rst_hsync", s_hsync, 0);
        check("s_vs_rst_video_on", s_video_on, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
